div_unit: RTL

- Multi-cycle 32-bit integer divider in the EX stage, serving MIPS DIV/DIVU.
- It is the requesting end of the stall protocol. While a division is in flight it raises stallreq_o, which is wired to the stall controller's stallreq_for_ex input. That freezes PC, IF, ID and EX until the quotient and remainder are ready for the HI/LO write.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Divider request/response bundle between EX decode (master) and div_unit (slave).
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                signed_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// Holds the pipeline via stallreq_o while a divide is in flight.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_dividend;   // magnitude, shifted left one bit per iteration
  logic [DATA_W-1:0]   r_divisor;    // magnitude
  logic [DATA_W:0]     r_rem;        // partial remainder, one guard bit
  logic [DATA_W-1:0]   r_quot;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sign1, r_sign2;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_stall, w_load, w_iter;
  logic [DATA_W:0]     w_shift, w_diff, w_rem_nx;
  logic                w_ge;
  logic [DATA_W-1:0]   w_quot_nx, w_q_fix, w_r_fix;
  logic                w_neg1, w_neg2;

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.stallreq_o = w_stall;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The remainder stays below the divisor, so the guard bit is a valid sign.
  assign w_shift   = {r_rem[DATA_W-1:0], r_dividend[DATA_W-1]};
  assign w_diff    = w_shift - {1'b0, r_divisor};
  assign w_ge      = ~w_diff[DATA_W];
  assign w_rem_nx  = w_ge ? w_diff : w_shift;
  assign w_quot_nx = {r_quot[DATA_W-2:0], w_ge};

  // Sign fix-up on the final step: quotient negative if signs differ,
  // remainder follows the dividend. Overflow case wraps naturally.
  assign w_q_fix = (r_sign1 ^ r_sign2) ? (~w_quot_nx + 1'b1) : w_quot_nx;
  assign w_r_fix = r_sign1 ? (~w_rem_nx[DATA_W-1:0] + 1'b1) : w_rem_nx[DATA_W-1:0];

  assign w_neg1 = bus.signed_i & bus.opdata1_i[DATA_W-1];
  assign w_neg2 = bus.signed_i & bus.opdata2_i[DATA_W-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode, stall request and datapath strobes
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_load  = 1'b0;
    w_iter  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          w_stall = 1'b1;
          if (bus.opdata2_i == '0) begin
            w_next = S_DIVZERO;
          end else begin
            w_next = S_ON;
            w_load = 1'b1;
          end
        end
      end
      S_DIVZERO: begin
        w_stall = 1'b1;
        w_next  = bus.annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        w_stall = 1'b1;
        if (bus.annul_i) begin
          w_next = S_IDLE;
        end else begin
          w_iter = 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) w_next = S_END;
        end
      end
      S_END: begin
        if (!bus.start_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) w_stall = 1'b0;
  end

  // Operand latch, iteration datapath and result/ready registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (w_load) begin
        r_dividend <= w_neg1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
        r_divisor  <= w_neg2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
        r_sign1    <= w_neg1;
        r_sign2    <= w_neg2;
        r_rem      <= '0;
        r_quot     <= '0;
        r_cnt      <= '0;
      end
      if (w_iter) begin
        r_dividend <= {r_dividend[DATA_W-2:0], 1'b0};
        r_rem      <= w_rem_nx;
        r_quot     <= w_quot_nx;
        r_cnt      <= r_cnt + 1'b1;
      end
      if (r_state == S_ON && w_next == S_END)
        r_result <= {w_r_fix, w_q_fix};
      else if (r_state == S_DIVZERO && w_next == S_END)
        r_result <= '0;
      r_ready <= (w_next == S_END);
    end
  end
endmodule
